div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 signed_div_i  in  1  1 = signed (two's-complement) divide; 0 = unsigned divide.
REQ-005 opdata1_i  in  32  dividend.
REQ-006 opdata2_i  in  32  divisor.
REQ-007 start_i  in  1  divide request; the requester holds it high until ready_o is seen, then drops it.
REQ-008 annul_i  in  1  cancel request, e.g. on a flushed branch shadow.
REQ-009 result_o  out  64  [63:32] = remainder (HI), [31:0] = quotient (LO); registered.
REQ-010 ready_o  out  1  result valid; registered.

Function
REQ-011 The block SHALL implement the states FREE, BY_ZERO, ON and END with a 6-bit iteration counter cnt.
REQ-012 FREE SHALL take no action while start_i=0 or annul_i=1.
REQ-013 FREE with start_i=1, annul_i=0 and opdata2_i=0 SHALL go to BY_ZERO.
REQ-014 FREE with start_i=1, annul_i=0 and opdata2_i≠0 SHALL go to ON on the same edge and SHALL:
- clear cnt;
- latch the signs of both operands and signed_div_i;
- latch the magnitudes: two's complement of an operand if signed_div_i=1 and its bit 31=1, else the raw value;
- load the 65-bit working register as {32'b0, |dividend|, 1'b0}.
REQ-015 Operand and mode inputs SHALL be ignored after the latch edge until the block returns to FREE.
REQ-016 While in ON with cnt<32 and annul_i=0, each edge SHALL:
- compute t = {1'b0, work[63:32]} − {1'b0, |divisor|} (33 bits);
- if t[32]=1, set work <= {work[63:0], 1'b0};
- else set work <= {t[31:0], work[31:0], 1'b1};
- increment cnt.
REQ-017 ON with cnt=32 SHALL do all of the following on one edge:
- quotient = work[31:0], negated if the latched mode is signed and the operand signs differ;
- remainder = work[64:33], negated if the latched mode is signed and the dividend was negative;
- result_o <= {remainder, quotient};
- ready_o <= 1;
- go to END and clear cnt.
REQ-018 BY_ZERO SHALL on the next edge set result_o <= 0, ready_o <= 1 and go to END.
REQ-019 END SHALL hold result_o and ready_o while start_i=1.
REQ-020 END with start_i=0 SHALL on the next edge go to FREE with ready_o <= 0 and result_o <= 0.
REQ-021 annul_i=1 in ON SHALL on the next edge go to FREE with ready_o=0 and result_o=0, and clear cnt.
REQ-022 annul_i in BY_ZERO or END SHALL have no effect.
REQ-023 Latency, counting the FREE edge that samples start_i as edge 1:
- nonzero divisor: ready_o SHALL rise after edge 34;
- zero divisor: ready_o SHALL rise after edge 2.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder, with the remainder taking the dividend's sign in signed mode.
REQ-026 ready_o SHALL never be 1 outside END.

Reset
REQ-027 Asserting rst SHALL, without waiting for a clock edge, force:
- state = FREE, cnt = 0, working register = 0;
- ready_o = 0, result_o = 0.
REQ-028 Reset asserted mid-divide SHALL discard the operation.
REQ-029 After rst deasserts, the first edge with start_i=1 SHALL begin a new divide.

Verification
REQ-030 Unsigned 100 / 7, start held high -> ready_o rises after edge 34, result_o = {32'd2, 32'd14}; start dropped -> ready_o = 0 and state FREE next edge.
REQ-031 Signed −7 / 2 (0xFFFFFFF9 / 0x2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; same operands unsigned -> {0x1, 0x7FFFFFFC}.
REQ-032 Divisor 0 (any dividend, either mode) -> ready_o = 1 after edge 2, result_o = 0; no ON cycles.
REQ-033 annul_i pulsed during the 10th ON iteration -> FREE next edge, ready_o stays 0. A following 9 / 3 start -> {0, 3} after 34 edges.
REQ-034 rst asserted mid-ON between clock edges -> ready_o = 0, result_o = 0 immediately. After release, signed 0x80000000 / 0xFFFFFFFF -> {0x0, 0x80000000}.
REQ-035 Operands changed every cycle during ON (unsigned 0xFFFFFFFF / 1 latched) -> result_o = {0x0, 0xFFFFFFFF}.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider.
//   signed_div_i : 1 = two's-complement divide, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request; held high by the requester until ready_o is seen
//   annul_i      : cancel an in-flight divide
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
// master = requester side, slave = divider side.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider, one quotient bit per clock.
// Signed operands are converted to magnitudes at start, divided unsigned,
// and the signs are restored on completion. A zero divisor returns 0 after
// two edges without iterating.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : div_unit_if.slave (operands, start/annul, result/ready)
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam logic [1:0] StFree   = 2'd0;
    localparam logic [1:0] StByZero = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StEnd    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // [64:33] partial remainder after the last shift, [31:0] quotient bits.
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag1, mag2;
    logic [32:0] diff;
    logic [31:0] quot, rem;

    always_comb begin
        mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1)
                                                       : bus.opdata1_i;
        mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1)
                                                       : bus.opdata2_i;
    end

    // Trial subtraction; bit 32 set means the divisor did not fit.
    assign diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    always_comb begin
        quot = (signed_q && (sign1_q ^ sign2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem  = (signed_q && sign1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            StFree: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        state_d   = StOn;
                        cnt_d     = 6'd0;
                        signed_d  = bus.signed_div_i;
                        sign1_d   = bus.opdata1_i[31];
                        sign2_d   = bus.opdata2_i[31];
                        divisor_d = mag2;
                        work_d    = {32'd0, mag1, 1'b0};
                    end
                end
            end

            StByZero: begin
                result_d = 64'd0;
                ready_d  = 1'b1;
                state_d  = StEnd;
            end

            StOn: begin
                if (bus.annul_i) begin
                    state_d  = StFree;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else if (cnt_q < 6'd32) begin
                    if (diff[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                    cnt_d    = 6'd0;
                end
            end

            StEnd: begin
                if (!bus.start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end

            default: begin
                state_d = StFree;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic clk;
    logic rst;
    int   cyc;
    int   passed;
    int   total;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          rdy_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: plain integer division in 64-bit arithmetic, low words kept.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    // Monitor: every rising ready_o consumes one scoreboard entry.
    logic rdy_prev;
    initial rdy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.ready_o && !rdy_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 1'b0, bus.result_o, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check(e.name, bus.result_o === e.res, bus.result_o, e.res);
                check({e.name, "_latency"}, cyc == e.rdy_cyc, 64'(cyc), 64'(e.rdy_cyc));
            end
        end
        rdy_prev <= bus.ready_o;
    end

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int hold,
                           input bit scramble, input bit rst_in_end);
        exp_t e;
        bit   got;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        e.res     = exp;
        e.rdy_cyc = cyc + ((b == 32'd0) ? 2 : 34);
        e.name    = name;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                got = 1'b1;
                break;
            end
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom);
            end
        end
        check({name, "_done"}, got, 64'(got), 64'd1);
        if (!got) sb_q.delete();
        repeat (hold) @(negedge clk);
        if (rst_in_end) begin
            #2 rst = 1'b1;
            #1 check({name, "_async_rst"}, bus.ready_o == 1'b0 && bus.result_o == 64'd0,
                     bus.result_o, 64'd0);
            bus.start_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            bus.start_i = 1'b0;
            @(negedge clk);
            check({name, "_drop"}, bus.ready_o == 1'b0 && bus.result_o == 64'd0,
                  {bus.result_o[62:0], bus.ready_o}, 64'd0);
        end
    endtask

    initial begin
        bit          sgn;
        logic [31:0] a, b;
        int          r;
        bit          stayed_low;

        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #1 check("reset_state", bus.ready_o == 1'b0 && bus.result_o == 64'd0,
                 bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("u_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 2, 1'b0, 1'b0);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b0, 1'b0);
        run_div("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 1, 1'b0, 1'b0);
        run_div("u_div0", 1'b0, 32'd12345, 32'd0, 64'd0, 1, 1'b0, 1'b0);
        run_div("s_div0", 1'b1, 32'h80000001, 32'd0, 64'd0, 0, 1'b0, 1'b0);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 0, 1'b0, 1'b0);

        // Annul during the 10th ON iteration (edge 11 after the start edge).
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        stayed_low = (bus.ready_o == 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) stayed_low = 1'b0;
        end
        check("annul_no_ready", stayed_low, 64'(!stayed_low), 64'd0);
        run_div("u_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 1'b0, 1'b0);

        // Reset mid-divide, between edges.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hDEADBEEF;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        bus.start_i = 1'b0;
        #1 check("rst_mid_on", bus.ready_o == 1'b0 && bus.result_o == 64'd0,
                 bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 0,
                1'b0, 1'b0);

        // Reset while a result is being presented.
        run_div("u_rst_end", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 1, 1'b0, 1'b1);

        // Operands toggled every cycle after the latch edge.
        run_div("u_scramble", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            r   = $urandom_range(0, 7);
            case (r)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (b != 32'd0 && (i % 4 == 3)) a = a >> $urandom_range(0, 31);
            run_div($sformatf("rand%0d", i), sgn, a, b, ref_div(sgn, a, b),
                    $urandom_range(0, 2), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
